// File: rtl/fhn_array.sv
// fhn_array: time-multiplexed array of N_NEURON FitzHugh-Nagumo neurons in
// signed Q(W-FRAC).FRAC fixed point, with one multiplier shared by all neurons.
// Each update tick walks the neurons through SQ/CUBE/UPD, stores the results
// in shadow registers, then commits every neuron in the same cycle.
//
// Ports:
//   CLOCK_50     clock
//   RESET        synchronous, active-high reset
//   i_ext        per-neuron signed stimulus current, neuron k at [k*W +: W]
//   ext_spike    per-neuron external synaptic spike
//   syn_w        signed global ring-coupling weight
//   v_out        committed membrane potentials, neuron k at [k*W +: W]
//   spike_out    spike flags, held from one commit to the next
//   spike_count  saturating spike counters, neuron k at [k*CNT_W +: CNT_W]
//   tick_done    one-cycle pulse in the COMMIT cycle
//   busy         high while the sequencer is not idle
//   overrun      sticky; a tick arrived while busy and was dropped
//
// Build option: define FHN_NOISE_EN to add LFSR noise to each neuron's input
// current. Without it the input current is purely i_ext plus coupling.

// Per-neuron committed state: v/w registers, hysteretic spike detector and
// saturating spike counter. Loaded only in the COMMIT cycle.
module fhn_lane #(
  parameter int W        = 18,
  parameter int CNT_W    = 18,
  parameter int V_INIT   = -57016,
  parameter int W_INIT   = -13893,
  parameter int SPIKE_TH = 32768
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             commit,
  input  logic [W-1:0]     v_new,
  input  logic [W-1:0]     w_new,
  output logic [W-1:0]     v,
  output logic [W-1:0]     w,
  output logic             spike,
  output logic [CNT_W-1:0] count
);
  localparam logic signed [W-1:0] TH = W'(SPIKE_TH);

  logic arm;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      v     <= W'(V_INIT);
      w     <= W'(W_INIT);
      spike <= 1'b0;
      count <= '0;
      arm   <= 1'b1;
    end else if (commit) begin
      v <= v_new;
      w <= w_new;
      // One count per excursion: disarm on the crossing, re-arm only once v
      // has come back below zero.
      if (arm && ($signed(v_new) >= TH)) begin
        spike <= 1'b1;
        arm   <= 1'b0;
        if (count != '1) count <= count + CNT_W'(1);
      end else begin
        spike <= 1'b0;
        if (v_new[W-1]) arm <= 1'b1;
      end
    end
  end
endmodule

module fhn_array #(
  parameter int N_NEURON = 2,
  parameter int W        = 18,
  parameter int FRAC     = 16,
  parameter int DIV_BITS = 6,
  parameter int DT_SHIFT = 4,
  parameter int W_SHIFT  = 9,
  parameter int V_INIT   = -57016,
  parameter int W_INIT   = -13893,
  parameter int SPIKE_TH = 32768,
  parameter int CNT_W    = 18
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic [N_NEURON*W-1:0]     i_ext,
  input  logic [N_NEURON-1:0]       ext_spike,
  input  logic [W-1:0]              syn_w,
  output logic [N_NEURON*W-1:0]     v_out,
  output logic [N_NEURON-1:0]       spike_out,
  output logic [N_NEURON*CNT_W-1:0] spike_count,
  output logic                      tick_done,
  output logic                      busy,
  output logic                      overrun
);
  localparam int KW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam int XW = W + 4;
  localparam logic [KW-1:0] K_LAST = KW'(N_NEURON - 1);
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_CUBE, S_UPD, S_COMMIT} state_t;

  // Inputs frozen for the whole tick so every neuron sees the same network.
  typedef struct packed {
    logic [N_NEURON-1:0][W-1:0] ie;
    logic [N_NEURON-1:0]        es;
    logic [N_NEURON-1:0]        sp;
    logic [W-1:0]               sw;
  } snap_t;

  state_t state, state_nx;
  snap_t  snap;
  logic [DIV_BITS-1:0] pre;
  logic [KW-1:0]       k;
  logic                tick;

  logic [N_NEURON-1:0][W-1:0]     v_q, w_q, v_sh, w_sh;
  logic [N_NEURON-1:0][CNT_W-1:0] cnt_q;
  logic [N_NEURON-1:0]            spk_q;

  logic signed [W-1:0]   v_k, w_k, i_k, v2, v3, mul_a, mul_b;
  logic signed [2*W-1:0] prod, prod_s;
  logic signed [XW-1:0]  v_x, w_x, v3_x, i_x, dv, dw, v_sum, w_sum;
  logic signed [W-1:0]   v_upd, w_upd;
  logic [KW-1:0]         k_prv;

  function automatic logic signed [W-1:0] sat_p(input logic signed [2*W-1:0] x);
    logic [W:0] hi;
    hi = x[2*W-1:W-1];
    if (&hi || ~|hi) return x[W-1:0];
    return x[2*W-1] ? SMIN : SMAX;
  endfunction

  function automatic logic signed [W-1:0] sat_x(input logic signed [XW-1:0] x);
    logic [XW-W:0] hi;
    hi = x[XW-1:W-1];
    if (&hi || ~|hi) return x[W-1:0];
    return x[XW-1] ? SMIN : SMAX;
  endfunction

  assign tick = (pre == '0);

  // ---- state register ----
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ---- next state ----
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (tick) state_nx = S_SQ;
      S_SQ:     state_nx = S_CUBE;
      S_CUBE:   state_nx = S_UPD;
      S_UPD:    state_nx = (k == K_LAST) ? S_COMMIT : S_SQ;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy      = 1'b0;
    tick_done = 1'b0;
    if (state != S_IDLE)   busy      = 1'b1;
    if (state == S_COMMIT) tick_done = 1'b1;
  end

  // ---- shared multiplier: v*(v/2) in SQ, v2*(v/2) in CUBE ----
  assign v_k   = v_q[k];
  assign w_k   = w_q[k];
  assign i_k   = snap.ie[k];
  assign mul_a = (state == S_CUBE) ? v2 : v_k;
  assign mul_b = v_k >>> 1;
  assign prod  = mul_a * mul_b;
  assign prod_s = prod >>> FRAC;

  // Ring predecessor of neuron k.
  assign k_prv = (k == '0) ? K_LAST : k - KW'(1);

`ifdef FHN_NOISE_EN
  logic [15:0] lfsr;
  logic signed [XW-1:0] noise_x;
  assign noise_x = $signed(lfsr[FRAC-9:0]);

  always_ff @(posedge CLOCK_50) begin
    if (RESET)               lfsr <= 16'hACE1;
    else if (state == S_UPD) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  // ---- Euler update for neuron k, widened to XW so no term can overflow ----
  always_comb begin
    v_x  = v_k;
    w_x  = w_k;
    v3_x = v3;
    i_x  = i_k;
    if (snap.sp[k_prv] || snap.es[k]) i_x = i_x + XW'($signed(snap.sw));
`ifdef FHN_NOISE_EN
    i_x = i_x + noise_x;
`endif
    dv    = ((v_x >>> 2) - v3_x - (w_x >>> 2) + (i_x >>> 2)) >>> DT_SHIFT;
    dw    = ((v_x >>> 1) - (w_x >>> 1)) >>> W_SHIFT;
    v_sum = v_x + dv;
    w_sum = w_x + dw;
    v_upd = sat_x(v_sum);
    w_upd = sat_x(w_sum);
  end

  // ---- datapath registers ----
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pre     <= '0;
      k       <= '0;
      v2      <= '0;
      v3      <= '0;
      snap    <= '0;
      v_sh    <= '0;
      w_sh    <= '0;
      overrun <= 1'b0;
    end else begin
      pre <= pre + DIV_BITS'(1);
      if (tick && (state != S_IDLE)) overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick) begin
          k    <= '0;
          snap <= '{ie: i_ext, es: ext_spike, sp: spk_q, sw: syn_w};
        end
        S_SQ:   v2 <= sat_p(prod_s);
        S_CUBE: v3 <= sat_p(prod_s);
        S_UPD: begin
          v_sh[k] <= v_upd;
          w_sh[k] <= w_upd;
          if (k != K_LAST) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---- per-neuron committed state ----
  for (genvar g = 0; g < N_NEURON; g++) begin : g_lane
    fhn_lane #(
      .W(W), .CNT_W(CNT_W), .V_INIT(V_INIT), .W_INIT(W_INIT), .SPIKE_TH(SPIKE_TH)
    ) u_lane (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .commit   (state == S_COMMIT),
      .v_new    (v_sh[g]),
      .w_new    (w_sh[g]),
      .v        (v_q[g]),
      .w        (w_q[g]),
      .spike    (spk_q[g]),
      .count    (cnt_q[g])
    );
  end

  assign v_out       = v_q;
  assign spike_out   = spk_q;
  assign spike_count = cnt_q;
endmodule

// File: tb/tb_fhn_array.sv
module tb_fhn_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;
  int pulses;

  localparam longint VI = -57016;

  // Default build
  logic        rst_a;
  logic [35:0] ie_a;
  logic [1:0]  es_a;
  logic [17:0] sw_a;
  logic [35:0] v_a, cn_a;
  logic [1:0]  sp_a;
  logic        dn_a, bz_a, ov_a;

  fhn_array u_a (
    .CLOCK_50(clk), .RESET(rst_a), .i_ext(ie_a), .ext_spike(es_a), .syn_w(sw_a),
    .v_out(v_a), .spike_out(sp_a), .spike_count(cn_a), .tick_done(dn_a),
    .busy(bz_a), .overrun(ov_a));

  // Tick period shorter than a tick's work
  logic        rst_b;
  logic [35:0] ie_b = '0;
  logic [1:0]  es_b = '0;
  logic [17:0] sw_b = '0;
  logic [35:0] v_b, cn_b;
  logic [1:0]  sp_b;
  logic        dn_b, bz_b, ov_b;

  fhn_array #(.DIV_BITS(2)) u_b (
    .CLOCK_50(clk), .RESET(rst_b), .i_ext(ie_b), .ext_spike(es_b), .syn_w(sw_b),
    .v_out(v_b), .spike_out(sp_b), .spike_count(cn_b), .tick_done(dn_b),
    .busy(bz_b), .overrun(ov_b));

  // Narrow counter
  logic        rst_c;
  logic [35:0] ie_c;
  logic [1:0]  es_c = '0;
  logic [17:0] sw_c = '0;
  logic [35:0] v_c;
  logic [7:0]  cn_c;
  logic [1:0]  sp_c;
  logic        dn_c, bz_c, ov_c;

  fhn_array #(.DIV_BITS(3), .CNT_W(4)) u_c (
    .CLOCK_50(clk), .RESET(rst_c), .i_ext(ie_c), .ext_spike(es_c), .syn_w(sw_c),
    .v_out(v_c), .spike_out(sp_c), .spike_count(cn_c), .tick_done(dn_c),
    .busy(bz_c), .overrun(ov_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---- reference model of the default-build array (N=2) ----
  longint mv[2], mw[2], mc[2];
  bit     ma[2], ms[2];

  function automatic longint sat(input longint x);
    if (x > 131071)  return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic longint sx(input logic [17:0] x);
    longint r;
    r = $signed(x);
    return r;
  endfunction

  function automatic logic [63:0] pk(input longint a0, input longint a1);
    return {28'd0, 18'(a1), 18'(a0)};
  endfunction

  task automatic m_reset();
    for (int j = 0; j < 2; j++) begin
      mv[j] = VI; mw[j] = -13893; mc[j] = 0; ma[j] = 1'b1; ms[j] = 1'b0;
    end
  endtask

  task automatic m_tick();
    longint vn[2], wn[2];
    bit sp[2];
    sp = ms;
    for (int j = 0; j < 2; j++) begin
      longint v, w, h, v2, v3, ci, dv;
      v  = mv[j];
      w  = mw[j];
      h  = v >>> 1;
      v2 = sat((v * h) >>> 16);
      v3 = sat((v2 * h) >>> 16);
      ci = sx(ie_a[j*18 +: 18]);
      if (sp[(j + 1) % 2] || es_a[j]) ci += sx(sw_a);
      dv = ((v >>> 2) - v3 - (w >>> 2) + (ci >>> 2)) >>> 4;
      vn[j] = sat(v + dv);
      wn[j] = sat(w + (((v >>> 1) - (w >>> 1)) >>> 9));
    end
    for (int j = 0; j < 2; j++) begin
      mv[j] = vn[j];
      mw[j] = wn[j];
      if (ma[j] && vn[j] >= 32768) begin
        ms[j] = 1'b1; ma[j] = 1'b0;
        if (mc[j] < 262143) mc[j]++;
      end else begin
        ms[j] = 1'b0;
        if (vn[j] < 0) ma[j] = 1'b1;
      end
    end
  endtask

  task automatic wait_a(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dn_a && cyc < 200);
    chk("done_a", {63'd0, dn_a}, 64'd1);
  endtask

  task automatic wait_c(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dn_c && cyc < 100);
    chk("done_c", {63'd0, dn_c}, 64'd1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ie_a = '0; es_a = '0; sw_a = '0; ie_c = '0;
    m_reset();
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_v",    v_a,  pk(VI, VI));
    chk("rst_spk",  sp_a, 64'd0);
    chk("rst_cnt",  cn_a, 64'd0);
    chk("rst_busy", bz_a, 64'd0);
    chk("rst_ovr",  ov_a, 64'd0);
    chk("rst_done", dn_a, 64'd0);

    // first tick fires straight out of reset; COMMIT 7 cycles after it
    rst_a = 1'b0;
    @(negedge clk);
    chk("busy1", bz_a, 64'd1);
    n = 1;
    while (!dn_a && n < 200) begin @(negedge clk); n++; end
    chk("lat", n, 64'd7);
    m_tick();
    @(negedge clk);
    chk("idle1", bz_a, 64'd0);
    chk("t1_v", v_a, pk(-57016, -57016));

    // hand-computed: w moves to -13936 then -13979, nudging v up by one LSB
    wait_a(n); m_tick(); @(negedge clk);
    chk("t2_v", v_a, pk(-57015, -57015));
    wait_a(n); m_tick(); @(negedge clk);
    chk("period", n, 64'd63);
    chk("t3_v", v_a, pk(-57014, -57014));

    // driven neuron 0, ring coupling into neuron 1, brief external spike on 1
    ie_a[17:0] = 18'h05999;
    sw_a       = 18'h01000;
    for (int t = 0; t < 400; t++) begin
      es_a[1] = (t >= 150 && t < 154);
      wait_a(n); m_tick(); @(negedge clk);
      chk("v",   v_a,  pk(mv[0], mv[1]));
      chk("spk", sp_a, {62'd0, ms[1], ms[0]});
      chk("cnt", cn_a, pk(mc[0], mc[1]));
    end
    chk("ovr_a", ov_a, 64'd0);

    // reset while the sequencer is in CUBE
    ie_a = '0; sw_a = '0; es_a = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bz_a && n < 100);
    chk("bz_seen", bz_a, 64'd1);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_busy", bz_a, 64'd0);
    chk("mid_v",    v_a,  pk(VI, VI));
    chk("mid_cnt",  cn_a, 64'd0);
    chk("mid_spk",  sp_a, 64'd0);
    rst_a = 1'b0;
    m_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (!dn_a && n < 200);
    chk("lat2", n, 64'd7);
    m_tick(); @(negedge clk);
    chk("r_t1_v", v_a, pk(-57016, -57016));
    wait_a(n); m_tick(); @(negedge clk);
    chk("r_t2_v", v_a, pk(-57015, -57015));

    // overrun: 4-cycle period, 8-cycle tick
    rst_b = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk("done_b", {63'd0, dn_b}, ((c % 8) == 7) ? 64'd1 : 64'd0);
      if (c == 1) chk("busy_b1", bz_b, 64'd1);
      if (c == 4) chk("ovr_b4",  ov_b, 64'd0);
      if (c == 5) chk("ovr_b5",  ov_b, 64'd1);
      if (c == 8) chk("busy_b8", bz_b, 64'd0);
    end
    chk("ovr_b_end", ov_b, 64'd1);

    // counter saturation: bang-bang drive for repeated spikes
    rst_c = 1'b0;
    ie_c[17:0] = 18'h1FFFF;
    pulses = 0;
    for (int t = 0; t < 3000 && pulses < 18; t++) begin
      wait_c(n); @(negedge clk);
      if (sp_c[0]) begin
        pulses++;
        ie_c[17:0] = 18'h20000;
      end else if (v_c[17]) begin
        ie_c[17:0] = 18'h1FFFF;
      end
      chk("cnt_c", cn_c[3:0], (pulses > 15) ? 15 : pulses);
    end
    chk("pulses", pulses, 64'd18);
    chk("cnt15", cn_c[3:0], 64'd15);
    chk("ovr_c", ov_c, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fhn_array.md
Name: fhn_array

Overview:
- Time-multiplexed array of N FitzHugh-Nagumo neurons in signed fixed point, sharing one multiplier.
- Successor to the single-neuron FHN core. Adds:
  - parametrised width and neuron count;
  - ring synaptic coupling;
  - external spike inputs;
  - hysteretic spike detection;
  - saturating per-neuron spike counters;
  - overrun detection.
- Sits between the board switches/GPIO inputs and the LED/GPIO spike outputs.

Parameters:
- N_NEURON, 2, number of neurons (1..16).
- W, 18, state/current word width.
- FRAC, 16, fractional bits (1.0 = 2^FRAC).
- DIV_BITS, 6, update period = 2^DIV_BITS clocks.
- DT_SHIFT, 4, Euler step shift for v.
- W_SHIFT, 9, Euler step shift for w.
- V_INIT, -57016, reset v (-0.870).
- W_INIT, -13893, reset w (-0.212).
- SPIKE_TH, 32768, spike threshold (+0.5).
- CNT_W, 18, spike counter width.

Ports:
- CLOCK_50 in 1: clock.
- RESET in 1: synchronous, active-high reset.
- i_ext in N_NEURON*W: per-neuron signed stimulus current; neuron k at [k*W +: W].
- ext_spike in N_NEURON: external synaptic spike per neuron.
- syn_w in W: signed global coupling weight.
- v_out out N_NEURON*W: committed membrane potentials.
- spike_out out N_NEURON: spike flags, held for one update period.
- spike_count out N_NEURON*CNT_W: saturating spike counts.
- tick_done out 1: one-cycle pulse when a tick commits.
- busy out 1: high while the FSM is not IDLE.
- overrun out 1: sticky; set when a tick is missed.

Behaviour:
- Reset (RESET=1 at a clock edge, regardless of FSM state):
  - all v = V_INIT, all w = W_INIT;
  - prescaler, spike_out, spike_count, arm flags (set to 1), tick_done, busy, overrun all cleared;
  - FSM to IDLE;
  - reset mid-tick discards partial shadow results.
- Prescaler: DIV_BITS-bit free-running counter. tick = (counter==0).
- FSM states: IDLE, SQ, CUBE, UPD, COMMIT.
- IDLE: on tick → SQ with k=0; snapshot i_ext, ext_spike, syn_w and the previous spike_out.
- SQ (neuron k): p = v*(v>>>1) at 2W width; v2 = p>>>FRAC saturated to W.
- CUBE: p = v2*(v>>>1); v3 = p>>>FRAC saturated to W.
- UPD:
  - I = i_ext[k] + (syn_w if spike_prev[(k-1) mod N] or ext_spike[k], else 0).
  - dv = ((v>>>2) - v3 - (w>>>2) + (I>>>2)) >>> DT_SHIFT, computed at W+4 bits.
  - v_new = v + dv, saturated to W.
  - w_new = w + (((v>>>1) - (w>>>1)) >>> W_SHIFT), saturated.
  - Results go to shadow registers. If k < N-1: k++ → SQ; else → COMMIT.
- COMMIT (one cycle):
  - shadow copied to v/w for all neurons simultaneously (synchronous network update);
  - spike detect per neuron;
  - tick_done=1;
  - → IDLE.
- Latency: tick at cycle t; COMMIT at cycle t+3N+1; v_out updated at t+3N+2.
- Spike detect:
  - if arm=1 and v_new >= SPIKE_TH: spike_out[k]=1, arm=0, counter increments;
  - else spike_out[k]=0;
  - arm returns to 1 when v_new < 0.
- Counter saturates at 2^CNT_W - 1; no wrap.
- Overrun: if tick occurs while FSM is not IDLE, that tick is dropped and overrun=1 until RESET.
- All arithmetic is signed with arithmetic shifts. Saturation clamps to [-2^(W-1), 2^(W-1)-1].

Optional Feature:
- FHN_NOISE_EN defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset), stepped once per UPD;
  - its low FRAC-8 bits, sign-extended, are added to I.
- FHN_NOISE_EN undefined: no LFSR; I is exactly as specified above.

Test Plan:
- N=2, i_ext=0, syn_w=0, 2000 ticks → v settles within ±0x0400 of the fixed rest point; spike_out never 1; counts 0; overrun 0.
- i_ext[0]=0x0_5999 → neuron0 spikes periodically. Each spike_out pulse spans exactly one update period, and count0 increments once per pulse. No double count while v stays above threshold.
- Coupling: neuron0 driven as above, neuron1 i_ext=0, syn_w=0x0_1000 → neuron1 UPD adds +0x1000 to I only in the tick after a spike0 pulse. Check v1 shadow against a reference model, bit-exact.
- CNT_W=4, strong drive → count0 reaches 15 and stays 15.
- DIV_BITS=2, N=2 (7-cycle tick > 4-cycle period) → overrun=1 after the first missed tick; tick_done every second period.
- Assert RESET during CUBE → next cycle FSM is IDLE, v=V_INIT, busy=0; the first tick after release produces a normal commit.
